// File: rtl/mem_addr_ctl.sv
// Memory address controller: combinational normal-mode address mux plus the
// exception vector-fetch sequence (IDLE -> VEC -> FETCH) ending in a one-cycle PC load.
module mem_addr_ctl #(
    parameter int ADDR_W   = 32,
    parameter int N_SRC    = 3,
    parameter int N_EXC    = 3,
    parameter int VEC_BASE = 253,
    parameter int MEM_LAT  = 1,
    parameter int PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_SRC*ADDR_W-1:0]  src_data,
    input  logic [$clog2(N_SRC)-1:0] src_sel,
    input  logic [N_EXC-1:0]         exc_raise,
    input  logic [ADDR_W-1:0]        pc_in,
    input  logic [7:0]               mem_rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     exc_busy,
    output logic [$clog2(N_EXC)-1:0] exc_cause,
    output logic [ADDR_W-1:0]        epc,
    output logic                     pc_load,
    output logic [ADDR_W-1:0]        pc_load_val
);
    localparam int SEL_W   = $clog2(N_SRC);
    localparam int CAUSE_W = $clog2(N_EXC);
    localparam int CNT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_VEC,
        S_FETCH
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CAUSE_W-1:0] r_exc_cause;
    logic [ADDR_W-1:0]  r_epc;
    logic [CAUSE_W-1:0] w_exc_idx;
    logic               w_accept;
    logic [ADDR_W-1:0]  w_src_addr;
    logic [ADDR_W-1:0]  w_vec_addr;

    // Scanning from the top down leaves the lowest set bit, i.e. the highest priority cause.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_exc_idx = '0;
        for (int i = N_EXC - 1; i >= 0; i--) begin
            if (exc_raise[i]) w_exc_idx = CAUSE_W'(i);
        end
    end

    always_comb begin
        w_src_addr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_sel == SEL_W'(i)) w_src_addr = src_data[i*ADDR_W +: ADDR_W];
        end
    end

    assign w_accept   = (r_state == S_IDLE) && (|exc_raise);
    assign w_vec_addr = ADDR_W'(VEC_BASE) + ADDR_W'(r_exc_cause);

    always_comb begin
        w_next_state = r_state;
        mem_addr     = w_src_addr;
        exc_busy     = 1'b0;
        pc_load      = 1'b0;
        pc_load_val  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next_state = S_VEC;
            end
            S_VEC: begin
                mem_addr = w_vec_addr;
                exc_busy = 1'b1;
                if (r_cnt == '0) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_addr     = w_vec_addr;
                exc_busy     = 1'b1;
                pc_load      = 1'b1;
                pc_load_val  = {{(ADDR_W-8){1'b0}}, mem_rdata};
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_exc_cause <= '0;
            r_epc       <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cnt       <= CNT_W'(MEM_LAT - 1);
                r_exc_cause <= w_exc_idx;
                r_epc       <= pc_in - ADDR_W'(PC_STEP);
            end else if (r_state == S_VEC && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign exc_cause = r_exc_cause;
    assign epc       = r_epc;

endmodule

// File: tb/tb_mem_addr_ctl.sv
// Self-checking bench for mem_addr_ctl: two instances (MEM_LAT = 1 and 3) share stimulus
// and are compared every cycle against a cycle-count reference model, plus directed checks.
module tb_mem_addr_ctl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [95:0] src_data;
    logic [1:0]  src_sel;
    logic [2:0]  exc_raise;
    logic [31:0] pc_in;
    logic [7:0]  mem_rdata;

    logic [31:0] mem_addr_o    [2];
    logic [1:0]  busy_o;
    logic [1:0]  cause_o       [2];
    logic [31:0] epc_o         [2];
    logic [1:0]  pl_o;
    logic [31:0] plv_o         [2];

    int n_checks = 0;
    int n_errors = 0;

    // Model: m_k = cycles elapsed since the exception was accepted (0 = idle).
    int          m_k     [2] = '{0, 0};
    logic [1:0]  m_cause [2] = '{2'd0, 2'd0};
    logic [31:0] m_epc   [2] = '{32'd0, 32'd0};
    int          n_pl    [2] = '{0, 0};

    always #5 clk = ~clk;

    mem_addr_ctl #(.MEM_LAT(1)) u_lat1 (
        .clk(clk), .reset_n(reset_n), .src_data(src_data), .src_sel(src_sel),
        .exc_raise(exc_raise), .pc_in(pc_in), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr_o[0]), .exc_busy(busy_o[0]), .exc_cause(cause_o[0]),
        .epc(epc_o[0]), .pc_load(pl_o[0]), .pc_load_val(plv_o[0])
    );

    mem_addr_ctl #(.MEM_LAT(3)) u_lat3 (
        .clk(clk), .reset_n(reset_n), .src_data(src_data), .src_sel(src_sel),
        .exc_raise(exc_raise), .pc_in(pc_in), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr_o[1]), .exc_busy(busy_o[1]), .exc_cause(cause_o[1]),
        .epc(epc_o[1]), .pc_load(pl_o[1]), .pc_load_val(plv_o[1])
    );

    function automatic int lat(input int j);
        return (j == 0) ? 1 : 3;
    endfunction

    function automatic logic [1:0] lowest(input logic [2:0] e);
        for (int i = 0; i < 3; i++) begin
            if (e[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    function automatic logic [31:0] idle_addr();
        if (src_sel == 2'd3) return 32'd0;
        return src_data[src_sel*32 +: 32];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        for (int j = 0; j < 2; j++) begin
            if (!reset_n) begin
                m_k[j]     = 0;
                m_cause[j] = 2'd0;
                m_epc[j]   = 32'd0;
            end else if (m_k[j] == 0) begin
                if (exc_raise != 3'd0) begin
                    m_k[j]     = 1;
                    m_cause[j] = lowest(exc_raise);
                    m_epc[j]   = pc_in - 32'd4;
                end
            end else if (m_k[j] == lat(j) + 1) begin
                m_k[j] = 0;
            end else begin
                m_k[j] = m_k[j] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            logic        e_busy;
            logic        e_pl;
            logic [31:0] e_addr;
            string       tag;
            tag    = $sformatf("lat%0d", lat(j));
            e_busy = (m_k[j] != 0);
            e_pl   = (m_k[j] == lat(j) + 1);
            e_addr = e_busy ? (32'd253 + 32'(m_cause[j])) : idle_addr();
            check({tag, " mem_addr"}, mem_addr_o[j], e_addr);
            check({tag, " exc_busy"}, 32'(busy_o[j]), 32'(e_busy));
            check({tag, " exc_cause"}, 32'(cause_o[j]), 32'(m_cause[j]));
            check({tag, " epc"}, epc_o[j], m_epc[j]);
            check({tag, " pc_load"}, 32'(pl_o[j]), 32'(e_pl));
            check({tag, " pc_load_val"}, plv_o[j], e_pl ? {24'd0, mem_rdata} : 32'd0);
            if (pl_o[j]) n_pl[j]++;
        end
    end

    initial begin
        logic [31:0] mux_exp [4] = '{32'h100, 32'h200, 32'h300, 32'h0};
        int snap;

        reset_n   = 1'b0;
        src_data  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        src_sel   = 2'd0;
        exc_raise = 3'd0;
        pc_in     = 32'd0;
        mem_rdata = 8'd0;
        #2;
        for (int j = 0; j < 2; j++) begin
            check("reset exc_busy", 32'(busy_o[j]), 32'd0);
            check("reset epc", epc_o[j], 32'd0);
            check("reset exc_cause", 32'(cause_o[j]), 32'd0);
            check("reset pc_load", 32'(pl_o[j]), 32'd0);
            check("reset pc_load_val", plv_o[j], 32'd0);
            check("reset mem_addr", mem_addr_o[j], 32'h100);
        end
        tick(2);
        reset_n = 1'b1;
        tick(1);

        // Normal mux sweep, including the out-of-range select.
        for (int s = 0; s < 4; s++) begin
            src_sel = 2'(s);
            @(negedge clk);
            check($sformatf("mux sel%0d", s), mem_addr_o[0], mux_exp[s]);
            check("mux exc_busy", 32'(busy_o[0]), 32'd0);
            tick(1);
        end
        src_sel = 2'd0;

        // Overflow with MEM_LAT = 1.
        pc_in     = 32'h48;
        exc_raise = 3'b010;
        tick(1);
        exc_raise = 3'd0;
        mem_rdata = 8'h7C;
        @(negedge clk);
        check("ovf t+1 mem_addr", mem_addr_o[0], 32'd254);
        check("ovf t+1 exc_cause", 32'(cause_o[0]), 32'd1);
        check("ovf t+1 epc", epc_o[0], 32'h44);
        check("ovf t+1 lat3 mem_addr", mem_addr_o[1], 32'd254);
        tick(1);
        @(negedge clk);
        check("ovf t+2 pc_load", 32'(pl_o[0]), 32'd1);
        check("ovf t+2 pc_load_val", plv_o[0], 32'h7C);
        tick(1);
        @(negedge clk);
        check("ovf t+3 exc_busy", 32'(busy_o[0]), 32'd0);
        check("ovf t+3 pc_load", 32'(pl_o[0]), 32'd0);
        tick(3);

        // Priority: overflow beats divide-by-zero, which is dropped.
        snap      = n_pl[0];
        exc_raise = 3'b110;
        tick(1);
        exc_raise = 3'd0;
        @(negedge clk);
        check("prio exc_cause", 32'(cause_o[0]), 32'd1);
        check("prio mem_addr", mem_addr_o[0], 32'd254);
        tick(6);
        check("prio pc_load count", 32'(n_pl[0] - snap), 32'd1);

        // Raise during VEC on the MEM_LAT = 3 instance is ignored.
        snap      = n_pl[1];
        exc_raise = 3'b001;
        tick(1);
        exc_raise = 3'b100;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("busy-ign t+%0d mem_addr", c), mem_addr_o[1], 32'd253);
            check($sformatf("busy-ign t+%0d pc_load", c), 32'(pl_o[1]), (c == 4) ? 32'd1 : 32'd0);
            check($sformatf("busy-ign t+%0d exc_cause", c), 32'(cause_o[1]), 32'd0);
            tick(1);
            exc_raise = 3'd0;
        end
        @(negedge clk);
        check("busy-ign t+5 exc_busy", 32'(busy_o[1]), 32'd0);
        tick(4);
        check("busy-ign pc_load count", 32'(n_pl[1] - snap), 32'd1);

        // Back-to-back on the MEM_LAT = 1 instance.
        snap      = n_pl[0];
        exc_raise = 3'b100;
        tick(1);
        exc_raise = 3'd0;
        @(negedge clk);
        check("b2b first mem_addr", mem_addr_o[0], 32'd255);
        tick(1);
        @(negedge clk);
        check("b2b first pc_load", 32'(pl_o[0]), 32'd1);
        tick(1);
        exc_raise = 3'b001;
        @(negedge clk);
        check("b2b gap exc_busy", 32'(busy_o[0]), 32'd0);
        tick(1);
        exc_raise = 3'd0;
        @(negedge clk);
        check("b2b second mem_addr", mem_addr_o[0], 32'd253);
        check("b2b second exc_cause", 32'(cause_o[0]), 32'd0);
        tick(1);
        @(negedge clk);
        check("b2b second pc_load", 32'(pl_o[0]), 32'd1);
        tick(5);
        check("b2b pc_load count", 32'(n_pl[0] - snap), 32'd2);

        // Reset in the second VEC cycle of the MEM_LAT = 3 instance.
        snap      = n_pl[1];
        pc_in     = 32'h1000;
        exc_raise = 3'b010;
        tick(1);
        exc_raise = 3'd0;
        tick(1);
        reset_n = 1'b0;
        #1;
        check("rst-vec exc_busy", 32'(busy_o[1]), 32'd0);
        check("rst-vec epc", epc_o[1], 32'd0);
        check("rst-vec exc_cause", 32'(cause_o[1]), 32'd0);
        check("rst-vec pc_load", 32'(pl_o[1]), 32'd0);
        check("rst-vec mem_addr", mem_addr_o[1], 32'h100);
        tick(2);
        reset_n = 1'b1;
        tick(5);
        check("rst-vec pc_load count", 32'(n_pl[1] - snap), 32'd0);

        // Randomised traffic with occasional asynchronous reset pulses.
        for (int i = 0; i < 600; i++) begin
            src_data  = {$urandom, $urandom, $urandom};
            src_sel   = 2'($urandom_range(0, 3));
            exc_raise = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            pc_in     = $urandom;
            mem_rdata = 8'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                reset_n = 1'b0;
                #2;
                reset_n = 1'b1;
            end
            tick(1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
